// File: rtl/prio_dec_pkg.sv
// ============================================================================
// Module   : prio_dec_pkg
// Brief    : Shared constants, FSM state type and counter sizing for prio_dec.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package prio_dec_pkg;

  localparam int C_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Wide enough to hold the larger of the two reload values without wrapping.
  function automatic int f_cnt_w(input int pulse_len, input int gap_len);
    int m;
    m = (pulse_len > gap_len) ? pulse_len : gap_len;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/prio_dec_if.sv
// ============================================================================
// Module   : prio_dec_if
// Brief    : Index handshake and decoded-strobe bundle for prio_dec.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prio_dec_if
  import prio_dec_pkg::*;
#(
  parameter int IDX_W = C_IDX_W
) ();

  logic [IDX_W-1:0]    idx_in;
  logic                idx_valid;
  logic                idx_ready;
  logic [2**IDX_W-1:0] dec_out;
  logic                dec_valid;
  logic                busy;

  modport master (
    output idx_in,
    output idx_valid,
    input  idx_ready,
    input  dec_out,
    input  dec_valid,
    input  busy
  );

  modport slave (
    input  idx_in,
    input  idx_valid,
    output idx_ready,
    output dec_out,
    output dec_valid,
    output busy
  );

endinterface

`default_nettype wire

// File: rtl/prio_dec_onehot.sv
// ============================================================================
// Module   : prio_dec_onehot
// Brief    : Combinational IDX_W-to-2**IDX_W one-hot decoder with enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_dec_onehot
  import prio_dec_pkg::*;
#(
  parameter int IDX_W = C_IDX_W
) (
  input  wire logic [IDX_W-1:0]    i_idx,
  input  wire logic                i_en,
  output logic      [2**IDX_W-1:0] o_onehot
);

  genvar k;
  generate
    for (k = 0; k < 2**IDX_W; k++) begin : g_line
      assign o_onehot[k] = i_en && (i_idx == IDX_W'(k));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/prio_dec.sv
// ============================================================================
// Module   : prio_dec
// Brief    : Sequential priority-index decoder: accepts an index and emits a
//            timed one-hot pulse followed by an idle gap.
//            Optional history register enabled by PRIO_DEC_HIST_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_dec
  import prio_dec_pkg::*;
#(
  parameter int IDX_W     = C_IDX_W,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  prio_dec_if.slave      bus
`ifdef PRIO_DEC_HIST_EN
  ,
  input  wire logic                hist_clr,
  output logic      [2**IDX_W-1:0] hist_out
`endif
);

  localparam int              C_N          = 2**IDX_W;
  localparam int              C_CNT_W      = f_cnt_w(PULSE_LEN, GAP_LEN);
  localparam logic [C_CNT_W-1:0] C_PULSE_LOAD = C_CNT_W'(PULSE_LEN - 1);
  localparam logic [C_CNT_W-1:0] C_GAP_LOAD   = C_CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [C_CNT_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 w_hs;
  logic                 w_pulse;
  logic [C_N-1:0]       w_dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_pulse       = 1'b0;
    bus.idx_ready = 1'b0;
    bus.busy      = 1'b1;
    bus.dec_valid = 1'b0;
    w_hs          = 1'b0;

    case (r_state)
      IDLE: begin
        bus.idx_ready = 1'b1;
        bus.busy      = 1'b0;
        w_hs          = bus.idx_valid;
        if (w_hs) begin
          w_idx_nxt   = bus.idx_in;
          w_cnt_nxt   = C_PULSE_LOAD;
          w_state_nxt = PULSE;
        end
      end
      PULSE: begin
        w_pulse       = 1'b1;
        bus.dec_valid = 1'b1;
        if (r_cnt == '0) begin
          if (GAP_LEN > 0) begin
            w_cnt_nxt   = C_GAP_LOAD;
            w_state_nxt = GAP;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  prio_dec_onehot #(
    .IDX_W (IDX_W)
  ) u_onehot (
    .i_idx    (r_idx),
    .i_en     (w_pulse),
    .o_onehot (w_dec)
  );

  assign bus.dec_out = w_dec;

`ifdef PRIO_DEC_HIST_EN
  logic [C_N-1:0] r_hist;
  logic           w_first;

  // The counter still holds its reload value only in the first PULSE cycle.
  assign w_first = (r_state == PULSE) && (r_cnt == C_PULSE_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
    end else if (hist_clr) begin
      r_hist <= w_first ? w_dec : '0;
    end else if (w_first) begin
      r_hist <= r_hist | w_dec;
    end
  end

  assign hist_out = r_hist;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prio_dec.sv
// ============================================================================
// Module   : tb_prio_dec
// Brief    : Directed self-checking bench for prio_dec (4/1 and 1/0 timings).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prio_dec;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  prio_dec_if #(.IDX_W(3)) if0 ();
  prio_dec_if #(.IDX_W(3)) if1 ();

`ifdef PRIO_DEC_HIST_EN
  logic       hist_clr;
  logic [7:0] hist_out;
`endif

  prio_dec #(.IDX_W(3), .PULSE_LEN(4), .GAP_LEN(1)) u0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (if0.slave)
`ifdef PRIO_DEC_HIST_EN
    ,
    .hist_clr (hist_clr),
    .hist_out (hist_out)
`endif
  );

  logic [7:0] hist_unused;
  prio_dec #(.IDX_W(3), .PULSE_LEN(1), .GAP_LEN(0)) u1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (if1.slave)
`ifdef PRIO_DEC_HIST_EN
    ,
    .hist_clr (1'b0),
    .hist_out (hist_unused)
`endif
  );

  // Observation word: {dec_out, dec_valid, busy, idx_ready}
  logic [10:0] obs0, obs1;
  assign obs0 = {if0.dec_out, if0.dec_valid, if0.busy, if0.idx_ready};
  assign obs1 = {if1.dec_out, if1.dec_valid, if1.busy, if1.idx_ready};

  task automatic test_reset();
    logic [10:0] exp;
    rst_n = 1'b0;
    if0.idx_valid = 1'b0; if0.idx_in = '0;
    if1.idx_valid = 1'b0; if1.idx_in = '0;
    repeat (2) @(negedge clk);
    exp = {8'h00, 3'b001};
    total++; if (obs0 !== exp) begin bad++; $display("FAIL reset_u0 got=%h want=%h", obs0, exp); end
    total++; if (obs1 !== exp) begin bad++; $display("FAIL reset_u1 got=%h want=%h", obs1, exp); end
    rst_n = 1'b1;
    if0.idx_valid = 1'b1; if0.idx_in = 3'd3;
    @(negedge clk);
    if0.idx_valid = 1'b0;
    @(negedge clk);
    exp = {8'h08, 3'b110};
    total++; if (obs0 !== exp) begin bad++; $display("FAIL pre_abort got=%h want=%h", obs0, exp); end
    #2 rst_n = 1'b0;
    #1;
    exp = {8'h00, 3'b001};
    total++; if (obs0 !== exp) begin bad++; $display("FAIL abort_mid_pulse got=%h want=%h", obs0, exp); end
    @(negedge clk);
    rst_n = 1'b1;
    if0.idx_valid = 1'b1; if0.idx_in = 3'd6;
    @(negedge clk);
    if0.idx_valid = 1'b0;
    exp = {8'h40, 3'b110};
    total++; if (obs0 !== exp) begin bad++; $display("FAIL post_reset_pulse got=%h want=%h", obs0, exp); end
    repeat (5) @(negedge clk);
    exp = {8'h00, 3'b001};
    total++; if (obs0 !== exp) begin bad++; $display("FAIL post_reset_idle got=%h want=%h", obs0, exp); end
  endtask

  task automatic test_single();
    logic [10:0] exp;
    if0.idx_valid = 1'b1; if0.idx_in = 3'd5;
    @(negedge clk);
    if0.idx_valid = 1'b0; if0.idx_in = 'x;
    for (int i = 0; i < 4; i++) begin
      exp = {8'b0010_0000, 3'b110};
      total++; if (obs0 !== exp) begin bad++; $display("FAIL single_pulse[%0d] got=%h want=%h", i, obs0, exp); end
      @(negedge clk);
    end
    exp = {8'h00, 3'b010};
    total++; if (obs0 !== exp) begin bad++; $display("FAIL single_gap got=%h want=%h", obs0, exp); end
    @(negedge clk);
    exp = {8'h00, 3'b001};
    total++; if (obs0 !== exp) begin bad++; $display("FAIL single_ready got=%h want=%h", obs0, exp); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp;
    if0.idx_valid = 1'b1; if0.idx_in = 3'd0;
    @(negedge clk);
    if0.idx_in = 3'd7;
    for (int i = 0; i < 4; i++) begin
      exp = {8'h01, 3'b110};
      total++; if (obs0 !== exp) begin bad++; $display("FAIL b2b_first[%0d] got=%h want=%h", i, obs0, exp); end
      @(negedge clk);
    end
    exp = {8'h00, 3'b010};
    total++; if (obs0 !== exp) begin bad++; $display("FAIL b2b_gap got=%h want=%h", obs0, exp); end
    @(negedge clk);
    exp = {8'h00, 3'b001};
    total++; if (obs0 !== exp) begin bad++; $display("FAIL b2b_ready_t6 got=%h want=%h", obs0, exp); end
    @(negedge clk);
    if0.idx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp = {8'h80, 3'b110};
      total++; if (obs0 !== exp) begin bad++; $display("FAIL b2b_second[%0d] got=%h want=%h", i, obs0, exp); end
      @(negedge clk);
    end
    exp = {8'h00, 3'b010};
    total++; if (obs0 !== exp) begin bad++; $display("FAIL b2b_gap2 got=%h want=%h", obs0, exp); end
    @(negedge clk);
    exp = {8'h00, 3'b001};
    total++; if (obs0 !== exp) begin bad++; $display("FAIL b2b_idle got=%h want=%h", obs0, exp); end
  endtask

  task automatic test_ignored();
    logic [10:0] exp;
    if0.idx_valid = 1'b1; if0.idx_in = 3'd2;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if0.idx_in = 3'(i + 3);
      exp = (i < 4) ? {8'h04, 3'b110} : {8'h00, 3'b010};
      total++; if (obs0 !== exp) begin bad++; $display("FAIL ignored[%0d] got=%h want=%h", i, obs0, exp); end
      @(negedge clk);
    end
    if0.idx_valid = 1'b0;
    exp = {8'h00, 3'b001};
    total++; if (obs0 !== exp) begin bad++; $display("FAIL ignored_idle got=%h want=%h", obs0, exp); end
    @(negedge clk);
    total++; if (obs0 !== exp) begin bad++; $display("FAIL ignored_no_extra got=%h want=%h", obs0, exp); end
  endtask

  task automatic test_gap0();
    logic [10:0] exp;
    if1.idx_valid = 1'b1; if1.idx_in = 3'd1;
    @(negedge clk);
    if1.idx_in = 3'd2;
    exp = {8'h02, 3'b110};
    total++; if (obs1 !== exp) begin bad++; $display("FAIL gap0_first got=%h want=%h", obs1, exp); end
    @(negedge clk);
    exp = {8'h00, 3'b001};
    total++; if (obs1 !== exp) begin bad++; $display("FAIL gap0_between got=%h want=%h", obs1, exp); end
    @(negedge clk);
    if1.idx_valid = 1'b0;
    exp = {8'h04, 3'b110};
    total++; if (obs1 !== exp) begin bad++; $display("FAIL gap0_second got=%h want=%h", obs1, exp); end
    @(negedge clk);
    exp = {8'h00, 3'b001};
    total++; if (obs1 !== exp) begin bad++; $display("FAIL gap0_idle got=%h want=%h", obs1, exp); end
  endtask

`ifdef PRIO_DEC_HIST_EN
  task automatic test_hist();
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
    total++; if (hist_out !== 8'h00) begin bad++; $display("FAIL hist_clear got=%h want=%h", hist_out, 8'h00); end
    if0.idx_valid = 1'b1; if0.idx_in = 3'd2;
    @(negedge clk);
    if0.idx_valid = 1'b0;
    @(negedge clk);
    total++; if (hist_out !== 8'h04) begin bad++; $display("FAIL hist_one got=%h want=%h", hist_out, 8'h04); end
    repeat (4) @(negedge clk);
    if0.idx_valid = 1'b1; if0.idx_in = 3'd6;
    @(negedge clk);
    if0.idx_valid = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (hist_out !== 8'h44) begin bad++; $display("FAIL hist_two got=%h want=%h", hist_out, 8'h44); end
    if0.idx_valid = 1'b1; if0.idx_in = 3'd0;
    @(negedge clk);
    if0.idx_valid = 1'b0;
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
    total++; if (hist_out !== 8'h01) begin bad++; $display("FAIL hist_clr_first got=%h want=%h", hist_out, 8'h01); end
    repeat (4) @(negedge clk);
  endtask
`endif

  initial begin
`ifdef PRIO_DEC_HIST_EN
    hist_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_ignored();
    test_gap0();
`ifdef PRIO_DEC_HIST_EN
    test_hist();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
